triangle_setup: RTL and testbench
=================================

# triangle_setup

Downstream neighbour of the 3D projector. Accepts the projector's packed screen-space triangle pulses, culls degenerate and fully off-screen triangles, computes doubled signed area and a screen-clamped bounding box, normalises winding, and buffers results in a FIFO. The rasterizer drains the FIFO through a valid/ready handshake. The projector has no backpressure, so overflow drops triangles and is flagged.

## Interface
Parameters:
- WIDTH, 1280, screen width in pixels
- HEIGHT, 720, screen height in pixels
- FIFO_DEPTH, 8, triangle FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- triangle_in  in  128  {color, x1, y1, x2, y2, x3, y3, depth}, 16 b each; coordinates are two's complement
- new_triangle_in  in  1  one-cycle pulse; triangle_in valid this cycle
- done_in  in  1  one-cycle pulse; no further triangles this frame
- triangle_out  out  128  same packing as the input, winding normalised
- bbox_out  out  44  {xmin, ymin, xmax, ymax}, 11 b each, clamped to the screen
- area_out  out  35  doubled triangle area, always > 0
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts the head
- done_out  out  1  one-cycle pulse; frame fully drained
- overflow_out  out  1  sticky; a triangle was dropped

## Operation
- **S1 (register on new_triangle_in):**
  - Compute edge differences as 17 b signed: dx2 = x2−x1, dy3 = y3−y1, dx3 = x3−x1, dy2 = y2−y1.
  - Compute raw bbox as signed 16 b min/max over the three x and three y values.
- **S2:**
  - area = dx2·dy3 − dx3·dy2, 35 b signed, with no truncation.
  - Cull if area == 0.
  - Cull if xmax < 0, xmin > WIDTH−1, ymax < 0, or ymin > HEIGHT−1 (signed compares).
  - If area < 0: swap (x2, y2) with (x3, y3) and negate area.
  - Clamp bbox x to [0, WIDTH−1] and y to [0, HEIGHT−1], then truncate to 11 b.
- **FIFO push:** a non-culled S2 result is pushed. Culled triangles vanish silently.
- **Full FIFO:**
  - A push while full with no pop in the same cycle drops the triangle and sets overflow_out.
  - A simultaneous push and pop while full is accepted with no drop.
- **Handshake:**
  - An entry pops on out_valid && out_ready.
  - Outputs hold stable while out_valid && !out_ready.
  - out_ready while empty is ignored.
- **done tracking:**
  - done_in sets done_pending.
  - done_out pulses for exactly one cycle in the first cycle where done_pending is set, S1/S2 are empty, and the FIFO is empty. That cycle clears done_pending.
  - done_in arriving while done_pending is already set is merged.
  - A new_triangle_in arriving in the same cycle as done_in is processed before done_out.
- **Reset:**
  - Reset asserted mid-operation flushes S1, S2 and the FIFO, and clears done_pending and overflow_out.
  - All outputs go to 0 immediately, asynchronously.

## Timing
- Throughput: one triangle per cycle in.
- Latency: new_triangle_in at cycle t → out_valid at cycle t+3 when the FIFO is empty (S1 at t+1, S2 at t+2, FIFO write at t+2, head visible at t+3).
- A pop at cycle k exposes the next entry at k+1, with no bubble.
- Empty pipeline: done_in at t → done_out at t+1.
- Reset values: triangle_out = 0, bbox_out = 0, area_out = 0, out_valid = 0, done_out = 0, overflow_out = 0.
- FIFO pointers are log2(FIFO_DEPTH)+1 b with a wrap bit. Full when the low bits are equal and the wrap bits differ.

## Structure
- Package gfx_pkg holds:
  - triangle field offsets and a packed triangle_t struct;
  - bbox_t (four 11 b fields);
  - AREA_W = 35.
- One sub-module, tri_fifo: synchronous FIFO, parameterised on width and depth. It exposes push, pop, full, empty and head, and uses async active-low reset.
- Setup math and done tracking stay in triangle_setup.

## Test plan
- **Basic CCW triangle.** Input (100,100), (200,100), (100,300), color 0xF800, depth 0x0040, out_ready = 1.
  - Response at t+3: area 20000, bbox {100,100,200,300}, triangle_out equal to the input.
- **CW triangle.** Input (100,100), (100,300), (200,100).
  - Response: area 20000, v2/v3 swapped to match the basic CCW case.
- **Culling.**
  - Collinear (0,0), (10,10), (20,20) → no out_valid.
  - Off-screen triangle with all x ≥ 1280 → no out_valid.
  - Partially off-screen (−50,−50), (50,−50), (−50,50) → bbox {0,0,50,50}.
- **Overflow.** FIFO_DEPTH = 8, out_ready = 0, 10 back-to-back pulses.
  - Required: 8 entries are stored and overflow_out rises when the 9th triangle reaches the FIFO.
  - Then, with out_ready = 1, exactly the first 8 drain in order.
- **done ordering.** 3 triangles followed by done_in, with out_ready toggling 1/0 each cycle.
  - Required: done_out pulses once, in the cycle after the third pop, never earlier.
- **Reset mid-stream.** Assert rst with 4 entries queued and one triangle in S2.
  - Required: all outputs are 0 immediately.
  - After release: out_valid stays 0 until a new triangle is sent; overflow_out stays 0.

Source files
------------

// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared triangle/bbox types and setup helpers
package gfx_pkg;
    localparam int TRI_W   = 128;
    localparam int COORD_W = 11;
    localparam int BBOX_W  = 4 * COORD_W;
    localparam int AREA_W  = 35;

    localparam int COLOR_OFS = 112;
    localparam int X1_OFS    = 96;
    localparam int Y1_OFS    = 80;
    localparam int X2_OFS    = 64;
    localparam int Y2_OFS    = 48;
    localparam int X3_OFS    = 32;
    localparam int Y3_OFS    = 16;
    localparam int DEPTH_OFS = 0;

    typedef struct packed {
        logic [15:0] color;
        logic [15:0] x1;
        logic [15:0] y1;
        logic [15:0] x2;
        logic [15:0] y2;
        logic [15:0] x3;
        logic [15:0] y3;
        logic [15:0] depth;
    } triangle_t;

    typedef struct packed {
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymax;
    } bbox_t;

    function automatic logic signed [16:0] sext17(input logic [15:0] v);
        return {v[15], v};
    endfunction

    function automatic logic signed [15:0] min3(input logic signed [15:0] a, input logic signed [15:0] b,
                                                input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic signed [15:0] max3(input logic signed [15:0] a, input logic signed [15:0] b,
                                                input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [COORD_W-1:0] clamp11(input logic signed [15:0] v, input logic signed [15:0] hi);
        if (v < 16'sd0) return '0;
        if (v > hi) return hi[COORD_W-1:0];
        return v[COORD_W-1:0];
    endfunction
endpackage

// File: rtl/tri_fifo.sv
// rtl/tri_fifo.sv - synchronous FIFO with wrap-bit pointers
module tri_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         wr_en, rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push && (!full || rd_en);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (rd_en) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/triangle_setup.sv
// rtl/triangle_setup.sv - triangle cull, area, bbox and winding setup feeding a FIFO
module triangle_setup
    import gfx_pkg::*;
#(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TRI_W-1:0]  triangle_in,
    input  logic              new_triangle_in,
    input  logic              done_in,
    output logic [TRI_W-1:0]  triangle_out,
    output logic [BBOX_W-1:0] bbox_out,
    output logic [AREA_W-1:0] area_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done_out,
    output logic              overflow_out
);
    localparam int ENTRY_W = TRI_W + BBOX_W + AREA_W;
    localparam logic signed [15:0] X_LAST = 16'(WIDTH - 1);
    localparam logic signed [15:0] Y_LAST = 16'(HEIGHT - 1);

    typedef struct packed {
        logic               valid;
        triangle_t          verts;
        logic signed [16:0] dx2;
        logic signed [16:0] dy3;
        logic signed [16:0] dx3;
        logic signed [16:0] dy2;
        logic signed [15:0] xmin;
        logic signed [15:0] ymin;
        logic signed [15:0] xmax;
        logic signed [15:0] ymax;
    } s1_t;

    typedef struct packed {
        logic              valid;
        triangle_t         verts;
        bbox_t             bbox;
        logic [AREA_W-1:0] area;
    } s2_t;

    triangle_t tri_in;
    s1_t       s1_q, s1_d;
    s2_t       s2_q, s2_d;
    logic      done_pending_q, done_pending_d;
    logic      overflow_q, overflow_d;

    logic signed [AREA_W-1:0] m_dx2, m_dy3, m_dx3, m_dy2, area;
    logic                     off_screen, cw;
    logic                     fifo_full, fifo_empty, fifo_pop, done_fire;
    logic [ENTRY_W-1:0]       fifo_head;

    always_comb begin
        tri_in.color = triangle_in[COLOR_OFS +: 16];
        tri_in.x1    = triangle_in[X1_OFS +: 16];
        tri_in.y1    = triangle_in[Y1_OFS +: 16];
        tri_in.x2    = triangle_in[X2_OFS +: 16];
        tri_in.y2    = triangle_in[Y2_OFS +: 16];
        tri_in.x3    = triangle_in[X3_OFS +: 16];
        tri_in.y3    = triangle_in[Y3_OFS +: 16];
        tri_in.depth = triangle_in[DEPTH_OFS +: 16];
    end

    always_comb begin
        s1_d       = '0;
        s1_d.valid = new_triangle_in;
        s1_d.verts = tri_in;
        s1_d.dx2   = sext17(tri_in.x2) - sext17(tri_in.x1);
        s1_d.dy3   = sext17(tri_in.y3) - sext17(tri_in.y1);
        s1_d.dx3   = sext17(tri_in.x3) - sext17(tri_in.x1);
        s1_d.dy2   = sext17(tri_in.y2) - sext17(tri_in.y1);
        s1_d.xmin  = min3(tri_in.x1, tri_in.x2, tri_in.x3);
        s1_d.ymin  = min3(tri_in.y1, tri_in.y2, tri_in.y3);
        s1_d.xmax  = max3(tri_in.x1, tri_in.x2, tri_in.x3);
        s1_d.ymax  = max3(tri_in.y1, tri_in.y2, tri_in.y3);
    end

    // 17x17 signed products fit in 34 bits; their difference needs the full 35.
    always_comb begin
        m_dx2 = AREA_W'($signed(s1_q.dx2));
        m_dy3 = AREA_W'($signed(s1_q.dy3));
        m_dx3 = AREA_W'($signed(s1_q.dx3));
        m_dy2 = AREA_W'($signed(s1_q.dy2));
        area  = m_dx2 * m_dy3 - m_dx3 * m_dy2;
        cw    = area[AREA_W-1];
        off_screen = ($signed(s1_q.xmax) < 16'sd0) || ($signed(s1_q.xmin) > X_LAST) ||
                     ($signed(s1_q.ymax) < 16'sd0) || ($signed(s1_q.ymin) > Y_LAST);

        s2_d       = '0;
        s2_d.valid = s1_q.valid && (area != '0) && !off_screen;
        s2_d.verts = s1_q.verts;
        if (cw) begin
            s2_d.verts.x2 = s1_q.verts.x3;
            s2_d.verts.y2 = s1_q.verts.y3;
            s2_d.verts.x3 = s1_q.verts.x2;
            s2_d.verts.y3 = s1_q.verts.y2;
        end
        s2_d.area      = cw ? -area : area;
        s2_d.bbox.xmin = clamp11(s1_q.xmin, X_LAST);
        s2_d.bbox.ymin = clamp11(s1_q.ymin, Y_LAST);
        s2_d.bbox.xmax = clamp11(s1_q.xmax, X_LAST);
        s2_d.bbox.ymax = clamp11(s1_q.ymax, Y_LAST);
    end

    tri_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (s2_q.valid),
        .din   ({s2_q.verts, s2_q.bbox, s2_q.area}),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign done_fire = done_pending_q && !s1_q.valid && !s2_q.valid && fifo_empty;

    always_comb begin
        done_pending_d = (done_pending_q && !done_fire) || done_in;
        overflow_d     = overflow_q || (s2_q.valid && fifo_full && !fifo_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q           <= '0;
            s2_q           <= '0;
            done_pending_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            done_pending_q <= done_pending_d;
            overflow_q     <= overflow_d;
        end
    end

    // Gating the head by out_valid keeps outputs at zero whenever the FIFO is empty, including in reset.
    assign {triangle_out, bbox_out, area_out} = out_valid ? fifo_head : '0;
    assign done_out     = done_fire;
    assign overflow_out = overflow_q;
endmodule

// File: tb/tb_triangle_setup.sv
// tb/tb_triangle_setup.sv - scoreboard bench for triangle_setup
module tb_triangle_setup;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] triangle_in = '0;
    logic         new_triangle_in = 1'b0;
    logic         done_in = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] triangle_out;
    logic [43:0]  bbox_out;
    logic [34:0]  area_out;
    logic         out_valid, done_out, overflow_out;

    int vectors = 0;
    int miscompares = 0;
    logic [206:0] sb_q[$];

    always #5 clk = ~clk;

    triangle_setup #(.WIDTH(1280), .HEIGHT(720), .FIFO_DEPTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .triangle_in     (triangle_in),
        .new_triangle_in (new_triangle_in),
        .done_in         (done_in),
        .triangle_out    (triangle_out),
        .bbox_out        (bbox_out),
        .area_out        (area_out),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .done_out        (done_out),
        .overflow_out    (overflow_out)
    );

    function automatic logic [127:0] mk_tri(input int c, input int x1, input int y1, input int x2,
                                            input int y2, input int x3, input int y3, input int d);
        return {16'(c), 16'(x1), 16'(y1), 16'(x2), 16'(y2), 16'(x3), 16'(y3), 16'(d)};
    endfunction

    function automatic logic [206:0] mk_exp(input logic [127:0] t, input int xmin, input int ymin,
                                            input int xmax, input int ymax, input int area);
        return {t, 11'(xmin), 11'(ymin), 11'(xmax), 11'(ymax), 35'(area)};
    endfunction

    task automatic drive(input logic nt, input logic [127:0] t, input logic dn, input logic rdy);
        @(posedge clk);
        #1;
        new_triangle_in = nt;
        triangle_in     = t;
        done_in         = dn;
        out_ready       = rdy;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors += 6;
        if (triangle_out !== '0) begin miscompares++; $display("FAIL reset_tri: got %h want 0", triangle_out); end
        if (bbox_out !== '0) begin miscompares++; $display("FAIL reset_bbox: got %h want 0", bbox_out); end
        if (area_out !== '0) begin miscompares++; $display("FAIL reset_area: got %h want 0", area_out); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        if (done_out !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done_out); end
        if (overflow_out !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow_out); end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_basic_ccw();
        logic [127:0] a;
        logic [206:0] want;
        a = mk_tri(16'hF800, 100, 100, 200, 100, 100, 300, 16'h0040);
        sb_q.push_back(mk_exp(a, 100, 100, 200, 300, 20000));
        for (int c = 0; c < 8; c++) begin
            drive(c == 0, a, 1'b0, 1'b1);
            @(negedge clk);
            if (c == 2) begin
                vectors++;
                if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early: got %b want 0", out_valid); end
            end
            if (c == 3) begin
                vectors++;
                if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_latency: got %b want 1", out_valid); end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++; $display("FAIL basic_extra: got %h want nothing", {triangle_out, bbox_out, area_out});
                end else begin
                    want = sb_q.pop_front();
                    if ({triangle_out, bbox_out, area_out} !== want) begin
                        miscompares++; $display("FAIL basic_entry: got %h want %h", {triangle_out, bbox_out, area_out}, want);
                    end
                end
            end
        end
        vectors++;
        if (sb_q.size() != 0) begin miscompares++; $display("FAIL basic_drain: got %0d left want 0", sb_q.size()); end
    endtask

    task automatic test_cw();
        logic [127:0] a, b;
        logic [206:0] want;
        a = mk_tri(16'hF800, 100, 100, 200, 100, 100, 300, 16'h0040);
        b = mk_tri(16'hF800, 100, 100, 100, 300, 200, 100, 16'h0040);
        sb_q.push_back(mk_exp(a, 100, 100, 200, 300, 20000));
        for (int c = 0; c < 8; c++) begin
            drive(c == 0, b, 1'b0, 1'b1);
            @(negedge clk);
            if (out_valid && out_ready) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++; $display("FAIL cw_extra: got %h want nothing", {triangle_out, bbox_out, area_out});
                end else begin
                    want = sb_q.pop_front();
                    if ({triangle_out, bbox_out, area_out} !== want) begin
                        miscompares++; $display("FAIL cw_entry: got %h want %h", {triangle_out, bbox_out, area_out}, want);
                    end
                end
            end
        end
        vectors++;
        if (sb_q.size() != 0) begin miscompares++; $display("FAIL cw_drain: got %0d left want 0", sb_q.size()); end
    endtask

    task automatic test_cull();
        logic [127:0] t [5];
        logic [206:0] want;
        int seen = 0;
        t[0] = mk_tri(1, 0, 0, 10, 10, 20, 20, 1);
        t[1] = mk_tri(2, 1280, 0, 1300, 0, 1280, 50, 2);
        t[2] = mk_tri(3, -50, -50, 50, -50, -50, 50, 3);
        t[3] = mk_tri(4, 1279, 0, 1300, 0, 1279, 10, 4);
        t[4] = mk_tri(5, 0, 720, 10, 720, 0, 730, 5);
        for (int c = 0; c < 12; c++) begin
            drive(c < 5, (c < 5) ? t[c] : '0, 1'b0, 1'b1);
            if (c == 2) sb_q.push_back(mk_exp(t[2], 0, 0, 50, 50, 10000));
            if (c == 3) sb_q.push_back(mk_exp(t[3], 1279, 0, 1279, 10, 210));
            @(negedge clk);
            if (out_valid && out_ready) begin
                vectors++;
                seen++;
                if (sb_q.size() == 0) begin
                    miscompares++; $display("FAIL cull_leak: got %h want nothing", {triangle_out, bbox_out, area_out});
                end else begin
                    want = sb_q.pop_front();
                    if ({triangle_out, bbox_out, area_out} !== want) begin
                        miscompares++; $display("FAIL cull_entry: got %h want %h", {triangle_out, bbox_out, area_out}, want);
                    end
                end
            end
        end
        vectors += 2;
        if (seen != 2) begin miscompares++; $display("FAIL cull_count: got %0d want 2", seen); end
        if (sb_q.size() != 0) begin miscompares++; $display("FAIL cull_drain: got %0d left want 0", sb_q.size()); end
    endtask

    task automatic test_overflow();
        logic [127:0] t;
        logic [206:0] want;
        for (int c = 0; c < 14; c++) begin
            t = mk_tri(c, 10 * c, 0, 10 * c + 100, 0, 10 * c, 50, c + 1);
            drive(c < 10, t, 1'b0, 1'b0);
            if (c < 8) sb_q.push_back(mk_exp(t, 10 * c, 0, 10 * c + 100, 50, 5000));
            @(negedge clk);
            if (c == 10) begin
                vectors++;
                if (overflow_out !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b want 0", overflow_out); end
            end
            if (c == 11) begin
                vectors++;
                if (overflow_out !== 1'b1) begin miscompares++; $display("FAIL ovf_rise: got %b want 1", overflow_out); end
            end
            if (c == 12) begin
                vectors++;
                if ({out_valid, triangle_out, bbox_out, area_out} !== {1'b1, sb_q[0]}) begin
                    miscompares++; $display("FAIL ovf_hold: got %h want %h", {triangle_out, bbox_out, area_out}, sb_q[0]);
                end
            end
        end
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            @(negedge clk);
            if (out_valid && out_ready) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++; $display("FAIL ovf_extra: got %h want nothing", {triangle_out, bbox_out, area_out});
                end else begin
                    want = sb_q.pop_front();
                    if ({triangle_out, bbox_out, area_out} !== want) begin
                        miscompares++; $display("FAIL ovf_entry: got %h want %h", {triangle_out, bbox_out, area_out}, want);
                    end
                end
            end
        end
        vectors += 2;
        if (sb_q.size() != 0) begin miscompares++; $display("FAIL ovf_drain: got %0d left want 0", sb_q.size()); end
        if (overflow_out !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow_out); end
    endtask

    task automatic test_done();
        logic [127:0] t;
        logic [206:0] want;
        int pops = 0;
        int last_pop = -10;
        int dones = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, '0, c == 0, 1'b0);
            @(negedge clk);
            if (c < 3) begin
                vectors++;
                if (done_out !== (c == 1)) begin miscompares++; $display("FAIL done_empty_c%0d: got %b want %b", c, done_out, c == 1); end
            end
        end
        for (int c = 0; c < 25; c++) begin
            t = mk_tri(c, 10 * c, 10, 10 * c + 40, 10, 10 * c, 30, c);
            drive(c < 3, t, c == 3, c[0]);
            if (c < 3) sb_q.push_back(mk_exp(t, 10 * c, 10, 10 * c + 40, 30, 800));
            @(negedge clk);
            if (out_valid && out_ready) begin
                vectors++;
                pops++;
                last_pop = c;
                if (sb_q.size() == 0) begin
                    miscompares++; $display("FAIL done_extra: got %h want nothing", {triangle_out, bbox_out, area_out});
                end else begin
                    want = sb_q.pop_front();
                    if ({triangle_out, bbox_out, area_out} !== want) begin
                        miscompares++; $display("FAIL done_entry: got %h want %h", {triangle_out, bbox_out, area_out}, want);
                    end
                end
            end
            if (done_out) begin
                vectors++;
                dones++;
                if (pops != 3 || c != last_pop + 1) begin
                    miscompares++; $display("FAIL done_order: got cycle %0d pops %0d want cycle %0d pops 3", c, pops, last_pop + 1);
                end
            end
        end
        vectors++;
        if (dones != 1) begin miscompares++; $display("FAIL done_count: got %0d want 1", dones); end
    endtask

    task automatic test_reset_midstream();
        logic [127:0] t;
        logic [206:0] want;
        for (int c = 0; c < 7; c++) begin
            t = mk_tri(c, 10 * c, 0, 10 * c + 100, 0, 10 * c, 50, c);
            drive(c < 5, t, 1'b0, 1'b0);
            if (c == 6) begin
                #2;
                vectors++;
                if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_prefill: got %b want 1", out_valid); end
                rst = 1'b0;
                #1;
                vectors += 6;
                if (triangle_out !== '0) begin miscompares++; $display("FAIL mid_tri: got %h want 0", triangle_out); end
                if (bbox_out !== '0) begin miscompares++; $display("FAIL mid_bbox: got %h want 0", bbox_out); end
                if (area_out !== '0) begin miscompares++; $display("FAIL mid_area: got %h want 0", area_out); end
                if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b want 0", out_valid); end
                if (done_out !== 1'b0) begin miscompares++; $display("FAIL mid_done: got %b want 0", done_out); end
                if (overflow_out !== 1'b0) begin miscompares++; $display("FAIL mid_ovf: got %b want 0", overflow_out); end
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            @(negedge clk);
            vectors += 2;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_valid: got %b want 0", out_valid); end
            if (overflow_out !== 1'b0) begin miscompares++; $display("FAIL post_ovf: got %b want 0", overflow_out); end
        end
        t = mk_tri(16'hF800, 100, 100, 200, 100, 100, 300, 16'h0040);
        sb_q.push_back(mk_exp(t, 100, 100, 200, 300, 20000));
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, t, 1'b0, 1'b1);
            @(negedge clk);
            if (out_valid && out_ready) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++; $display("FAIL post_extra: got %h want nothing", {triangle_out, bbox_out, area_out});
                end else begin
                    want = sb_q.pop_front();
                    if ({triangle_out, bbox_out, area_out} !== want) begin
                        miscompares++; $display("FAIL post_entry: got %h want %h", {triangle_out, bbox_out, area_out}, want);
                    end
                end
            end
        end
        vectors++;
        if (sb_q.size() != 0) begin miscompares++; $display("FAIL post_drain: got %0d left want 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_ccw();
        test_cw();
        test_cull();
        test_overflow();
        test_done();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
